decode_stage_ctrl: RTL and testbench
====================================

// Module: decode_stage_ctrl
// PURPOSE
//  Parametrised control FSM for the decode stage of the pipelined core.
//  Sequences instruction fetch, then the Dec/Exe buffer write and PC update.
//  Adds a configurable fetch latency, downstream back-pressure, a flush path,
//  a stall-cycle counter and an optional stall timeout.
//  With defaults, DownReady=1 and Flush=0, it matches the current 3-state decode control.
// PARAMETERS
//  FETCH_LAT      1   cycles spent in FETCH per instruction (>=1)
//  CNT_W          8   width of fetch and stall counters
//  STALL_TIMEOUT  0   max STALL cycles before forced exit; 0 = disabled (must be < 2^CNT_W)
// PORTS
//  CLK            in   1      clock, all state changes on posedge
//  RST            in   1      synchronous reset, active-high
//  SetStall       in   1      request stall; sampled only in DECODE on the write cycle
//  ClrStall       in   1      release stall; sampled only in STALL
//  Flush          in   1      discard in-flight instruction; sampled in every state
//  DownReady      in   1      Dec/Exe buffer can accept a write this cycle
//  DecExeBufferWr out  1      write strobe for the Dec/Exe buffer
//  PCRegWr        out  1      write strobe for the PC register
//  IsDecStall     out  1      FSM is in STALL
//  IsDecFlush     out  1      FSM is in FLUSH
//  StallTimeout   out  1      one-cycle pulse: stall ended by timeout
//  StallCount     out  CNT_W  cycles spent in the current or most recent stall
//  DecState       out  2      current state encoding (debug)
// BEHAVIOUR
//  - States: FETCH=2'b00, DECODE=2'b01, STALL=2'b10, FLUSH=2'b11.
//  - Reset: state=FETCH, fetch counter=0, StallCount=0.
//    All outputs 0 from the first cycle after reset, DecState=0.
//  - Priority of next-state causes: RST > Flush > all other inputs.
//  - Flush=1 in any state: next state is FLUSH. Writes in the current cycle are forced to 0.
//  - FETCH: all strobes 0. The fetch counter counts 0..FETCH_LAT-1.
//    At FETCH_LAT-1 the counter clears and the FSM goes to DECODE.
//    FETCH always lasts exactly FETCH_LAT cycles.
//  - DECODE:
//      DecExeBufferWr = PCRegWr = DownReady & ~Flush (combinational).
//      DownReady=0: hold in DECODE, no strobes, no limit on hold time.
//      DownReady=1: go to STALL if SetStall, else FETCH.
//  - STALL: IsDecStall=1, strobes 0.
//      StallCount is 0 on the first STALL cycle and increments each cycle.
//      It saturates at 2^CNT_W-1 and holds its value after the stall ends.
//      It is cleared only when STALL is entered again, or by reset.
//    Exit to FETCH when ClrStall=1.
//    If STALL_TIMEOUT!=0 and StallCount==STALL_TIMEOUT-1 with ClrStall=0:
//      StallTimeout=1 for that cycle, then exit to FETCH.
//      The stall therefore lasts STALL_TIMEOUT cycles.
//    ClrStall and timeout in the same cycle: ClrStall wins, no timeout pulse.
//  - FLUSH: exactly one cycle. IsDecFlush=1, strobes 0. Next state is FETCH.
//    Fetch counter is cleared. StallCount is held.
//    Flush asserted while in FLUSH: stay one more FLUSH cycle.
//  - All outputs are combinational from the registered state and counters, except that
//    DecExeBufferWr/PCRegWr also depend on DownReady/Flush, and StallTimeout on ClrStall.
//    No output is registered separately.
//  - Outside STALL, SetStall and ClrStall are ignored. Outside DECODE, DownReady is ignored.
// TESTING
//  T1 defaults, DownReady=1, no stall, after RST: DecState alternates 0,1.
//     Strobes are 1 on every 2nd cycle only.
//  T2 FETCH_LAT=3: strobe pattern 0,0,0,1 repeating; the fetch counter wraps cleanly.
//  T3 DownReady=0 for 4 cycles in DECODE: DecState=1 held, strobes 0.
//     DownReady rises -> strobes=1 that cycle, then FETCH.
//  T4 SetStall in DECODE, ClrStall after 5 STALL cycles:
//     IsDecStall=1 for 5 cycles, StallCount 0..4, holds 4 afterwards.
//  T5 STALL_TIMEOUT=4, ClrStall never: StallTimeout pulses on the 4th STALL cycle, then FETCH.
//     Repeat with ClrStall on that same cycle: no pulse.
//  T6 Flush during DECODE with DownReady=1: strobes 0, one FLUSH cycle, then FETCH.
//     RST during STALL: next cycle FETCH, StallCount=0.

Source files
------------

// File: rtl/decode_stage_ctrl.sv
// Decode-stage control FSM: sequences instruction fetch, then the Dec/Exe buffer
// write and PC update, with configurable fetch latency, downstream back-pressure,
// a flush path, a saturating stall-cycle counter and an optional stall timeout.
module decode_stage_ctrl #(
    parameter int unsigned FETCH_LAT     = 1,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned STALL_TIMEOUT = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SetStall,
    input  logic             ClrStall,
    input  logic             Flush,
    input  logic             DownReady,
    output logic             DecExeBufferWr,
    output logic             PCRegWr,
    output logic             IsDecStall,
    output logic             IsDecFlush,
    output logic             StallTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [1:0]       DecState
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DECODE = 2'b01,
        ST_STALL  = 2'b10,
        ST_FLUSH  = 2'b11
    } state_e;

    // Last fetch-counter value before moving to DECODE (FETCH_LAT of 0 behaves as 1).
    localparam logic [CNT_W-1:0] FETCH_LAST =
        CNT_W'((FETCH_LAT == 0) ? 0 : FETCH_LAT - 1);
    // StallCount value on the final cycle of a timed-out stall.
    localparam logic [CNT_W-1:0] STALL_LAST =
        CNT_W'((STALL_TIMEOUT == 0) ? 0 : STALL_TIMEOUT - 1);
    localparam logic             TIMEOUT_EN = (STALL_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall_last;

    // Stall has reached its timeout limit this cycle (only meaningful in STALL).
    assign stall_last = TIMEOUT_EN && (stall_cnt_q == STALL_LAST);

    // State and counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_FETCH;
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state and counter update; Flush overrides every other cause.
    always_comb begin
        state_d     = state_q;
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;

        unique case (state_q)
            ST_FETCH: begin
                if (fetch_cnt_q == FETCH_LAST) begin
                    fetch_cnt_d = '0;
                    state_d     = ST_DECODE;
                end else begin
                    fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                if (DownReady) begin
                    if (SetStall) begin
                        state_d     = ST_STALL;
                        stall_cnt_d = '0;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_STALL: begin
                if (ClrStall || stall_last) begin
                    state_d = ST_FETCH;
                end else if (stall_cnt_q != CNT_MAX) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                state_d     = ST_FETCH;
                fetch_cnt_d = '0;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (Flush) begin
            state_d     = ST_FLUSH;
            fetch_cnt_d = '0;
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Outputs decoded from registered state; strobes gated by DownReady/Flush.
    always_comb begin
        DecExeBufferWr = 1'b0;
        PCRegWr        = 1'b0;
        IsDecStall     = 1'b0;
        IsDecFlush     = 1'b0;
        StallTimeout   = 1'b0;
        StallCount     = stall_cnt_q;
        DecState       = state_q;

        unique case (state_q)
            ST_DECODE: begin
                DecExeBufferWr = DownReady & ~Flush;
                PCRegWr        = DownReady & ~Flush;
            end
            ST_STALL: begin
                IsDecStall   = 1'b1;
                StallTimeout = stall_last & ~ClrStall;
            end
            ST_FLUSH: begin
                IsDecFlush = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Scoreboard bench for decode_stage_ctrl: directed per-cycle vectors with
// hand-computed outputs for a default instance and a FETCH_LAT=3/timeout=4 instance.
module tb_decode_stage_ctrl;

    typedef struct packed {
        logic       wr;
        logic       pc;
        logic       stl;
        logic       fls;
        logic       to;
        logic [7:0] cnt;
        logic [1:0] st;
    } out_t;

    typedef struct packed {
        logic [4:0] in;   // {rst, set, clr, flush, dr}
        logic       chk;
        out_t       exp;
    } vec_t;

    typedef struct packed {
        logic       sel;
        logic [7:0] idx;
        out_t       exp;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic a_rst = 1'b1, a_set = 1'b0, a_clr = 1'b0, a_fl = 1'b0, a_dr = 1'b0;
    logic a_wr, a_pc, a_stl, a_fls, a_to;
    logic [7:0] a_cnt;
    logic [1:0] a_st;
    out_t a_out;

    // Instance B: FETCH_LAT=3, STALL_TIMEOUT=4
    logic b_rst = 1'b1, b_set = 1'b0, b_clr = 1'b0, b_fl = 1'b0, b_dr = 1'b0;
    logic b_wr, b_pc, b_stl, b_fls, b_to;
    logic [7:0] b_cnt;
    logic [1:0] b_st;
    out_t b_out;

    decode_stage_ctrl u_a (
        .CLK(clk), .RST(a_rst), .SetStall(a_set), .ClrStall(a_clr), .Flush(a_fl),
        .DownReady(a_dr), .DecExeBufferWr(a_wr), .PCRegWr(a_pc), .IsDecStall(a_stl),
        .IsDecFlush(a_fls), .StallTimeout(a_to), .StallCount(a_cnt), .DecState(a_st)
    );

    decode_stage_ctrl #(.FETCH_LAT(3), .CNT_W(8), .STALL_TIMEOUT(4)) u_b (
        .CLK(clk), .RST(b_rst), .SetStall(b_set), .ClrStall(b_clr), .Flush(b_fl),
        .DownReady(b_dr), .DecExeBufferWr(b_wr), .PCRegWr(b_pc), .IsDecStall(b_stl),
        .IsDecFlush(b_fls), .StallTimeout(b_to), .StallCount(b_cnt), .DecState(b_st)
    );

    assign a_out = {a_wr, a_pc, a_stl, a_fls, a_to, a_cnt, a_st};
    assign b_out = {b_wr, b_pc, b_stl, b_fls, b_to, b_cnt, b_st};

    int   total = 0;
    int   bad   = 0;
    sb_t  sb_q[$];
    vec_t va[$];
    vec_t vb[$];

    // flags = {wr, pc, stall, flush, timeout}
    function automatic vec_t v(input logic [4:0] in, input logic chk,
                               input logic [4:0] flags, input int cnt, input int st);
        vec_t r;
        r.in  = in;
        r.chk = chk;
        r.exp = {flags, 8'(cnt), 2'(st)};
        return r;
    endfunction

    // Monitor: compare DUT outputs against the queued expectation mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_t  e;
            out_t act;
            e   = sb_q.pop_front();
            act = e.sel ? b_out : a_out;
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL vec %s%0d: got={wr,pc,stl,fls,to,cnt,st}=%b required=%b",
                         e.sel ? "B" : "A", e.idx, act, e.exp);
            end
        end
    end

    // Apply one vector for the cycle after the next rising edge; queue its expectation.
    task automatic apply(input logic sel, input vec_t t, input int idx);
        @(posedge clk);
        #1;
        if (sel) {b_rst, b_set, b_clr, b_fl, b_dr} = t.in;
        else     {a_rst, a_set, a_clr, a_fl, a_dr} = t.in;
        if (t.chk) sb_q.push_back({sel, 8'(idx), t.exp});
    endtask

    initial begin
        // Instance A: T1 alternation, T3 back-pressure, T4 stall, T6 flush and reset-in-stall
        va.push_back(v(5'b10000, 0, 5'b00000, 0, 0)); // 0 reset
        va.push_back(v(5'b00001, 1, 5'b00000, 0, 0)); // 1 FETCH
        va.push_back(v(5'b00001, 1, 5'b11000, 0, 1)); // 2 DECODE write
        va.push_back(v(5'b00001, 1, 5'b00000, 0, 0)); // 3 FETCH
        va.push_back(v(5'b00001, 1, 5'b11000, 0, 1)); // 4 DECODE write
        va.push_back(v(5'b00000, 1, 5'b00000, 0, 0)); // 5 FETCH, DownReady ignored
        va.push_back(v(5'b00000, 1, 5'b00000, 0, 1)); // 6 DECODE hold
        va.push_back(v(5'b00000, 1, 5'b00000, 0, 1)); // 7
        va.push_back(v(5'b00000, 1, 5'b00000, 0, 1)); // 8
        va.push_back(v(5'b01000, 1, 5'b00000, 0, 1)); // 9 hold, SetStall w/o ready
        va.push_back(v(5'b00001, 1, 5'b11000, 0, 1)); // 10 ready rises
        va.push_back(v(5'b00001, 1, 5'b00000, 0, 0)); // 11 FETCH
        va.push_back(v(5'b01001, 1, 5'b11000, 0, 1)); // 12 DECODE + SetStall
        va.push_back(v(5'b00001, 1, 5'b00100, 0, 2)); // 13 STALL cnt0
        va.push_back(v(5'b00001, 1, 5'b00100, 1, 2)); // 14
        va.push_back(v(5'b00001, 1, 5'b00100, 2, 2)); // 15
        va.push_back(v(5'b00001, 1, 5'b00100, 3, 2)); // 16
        va.push_back(v(5'b00101, 1, 5'b00100, 4, 2)); // 17 ClrStall
        va.push_back(v(5'b01101, 1, 5'b00000, 4, 0)); // 18 FETCH, stall inputs ignored
        va.push_back(v(5'b00001, 1, 5'b11000, 4, 1)); // 19 DECODE, count held
        va.push_back(v(5'b00001, 1, 5'b00000, 4, 0)); // 20 FETCH
        va.push_back(v(5'b00011, 1, 5'b00000, 4, 1)); // 21 DECODE + Flush: no strobes
        va.push_back(v(5'b00001, 1, 5'b00010, 4, 3)); // 22 FLUSH
        va.push_back(v(5'b00001, 1, 5'b00000, 4, 0)); // 23 FETCH
        va.push_back(v(5'b00011, 1, 5'b00000, 4, 1)); // 24 DECODE + Flush
        va.push_back(v(5'b00011, 1, 5'b00010, 4, 3)); // 25 FLUSH + Flush
        va.push_back(v(5'b00001, 1, 5'b00010, 4, 3)); // 26 second FLUSH
        va.push_back(v(5'b00001, 1, 5'b00000, 4, 0)); // 27 FETCH
        va.push_back(v(5'b01001, 1, 5'b11000, 4, 1)); // 28 DECODE + SetStall
        va.push_back(v(5'b00001, 1, 5'b00100, 0, 2)); // 29 STALL cnt cleared
        va.push_back(v(5'b00001, 1, 5'b00100, 1, 2)); // 30
        va.push_back(v(5'b10001, 1, 5'b00100, 2, 2)); // 31 RST during STALL
        va.push_back(v(5'b00001, 1, 5'b00000, 0, 0)); // 32 FETCH, count reset
        va.push_back(v(5'b00001, 1, 5'b11000, 0, 1)); // 33 DECODE

        // Instance B: T2 fetch latency, T5 timeout and ClrStall-vs-timeout, flush mid-fetch
        vb.push_back(v(5'b10000, 0, 5'b00000, 0, 0)); // 0 reset
        vb.push_back(v(5'b00001, 1, 5'b00000, 0, 0)); // 1 FETCH fc0
        vb.push_back(v(5'b00001, 1, 5'b00000, 0, 0)); // 2 fc1
        vb.push_back(v(5'b00001, 1, 5'b00000, 0, 0)); // 3 fc2
        vb.push_back(v(5'b00001, 1, 5'b11000, 0, 1)); // 4 DECODE
        vb.push_back(v(5'b00001, 1, 5'b00000, 0, 0)); // 5
        vb.push_back(v(5'b00001, 1, 5'b00000, 0, 0)); // 6
        vb.push_back(v(5'b00001, 1, 5'b00000, 0, 0)); // 7
        vb.push_back(v(5'b00001, 1, 5'b11000, 0, 1)); // 8 DECODE
        vb.push_back(v(5'b00001, 1, 5'b00000, 0, 0)); // 9
        vb.push_back(v(5'b00001, 1, 5'b00000, 0, 0)); // 10
        vb.push_back(v(5'b00001, 1, 5'b00000, 0, 0)); // 11
        vb.push_back(v(5'b01001, 1, 5'b11000, 0, 1)); // 12 DECODE + SetStall
        vb.push_back(v(5'b00001, 1, 5'b00100, 0, 2)); // 13 STALL cnt0
        vb.push_back(v(5'b00001, 1, 5'b00100, 1, 2)); // 14
        vb.push_back(v(5'b00001, 1, 5'b00100, 2, 2)); // 15
        vb.push_back(v(5'b00001, 1, 5'b00101, 3, 2)); // 16 timeout pulse
        vb.push_back(v(5'b00001, 1, 5'b00000, 3, 0)); // 17 FETCH, count held
        vb.push_back(v(5'b00001, 1, 5'b00000, 3, 0)); // 18
        vb.push_back(v(5'b00001, 1, 5'b00000, 3, 0)); // 19
        vb.push_back(v(5'b01001, 1, 5'b11000, 3, 1)); // 20 DECODE + SetStall
        vb.push_back(v(5'b00001, 1, 5'b00100, 0, 2)); // 21
        vb.push_back(v(5'b00001, 1, 5'b00100, 1, 2)); // 22
        vb.push_back(v(5'b00001, 1, 5'b00100, 2, 2)); // 23
        vb.push_back(v(5'b00101, 1, 5'b00100, 3, 2)); // 24 ClrStall wins, no pulse
        vb.push_back(v(5'b00001, 1, 5'b00000, 3, 0)); // 25 FETCH fc0
        vb.push_back(v(5'b00011, 1, 5'b00000, 3, 0)); // 26 FETCH fc1 + Flush
        vb.push_back(v(5'b00001, 1, 5'b00010, 3, 3)); // 27 FLUSH
        vb.push_back(v(5'b00001, 1, 5'b00000, 3, 0)); // 28 FETCH fc0
        vb.push_back(v(5'b00001, 1, 5'b00000, 3, 0)); // 29 fc1
        vb.push_back(v(5'b00001, 1, 5'b00000, 3, 0)); // 30 fc2
        vb.push_back(v(5'b00001, 1, 5'b11000, 3, 1)); // 31 DECODE

        foreach (va[i]) apply(1'b0, va[i], i);
        foreach (vb[i]) apply(1'b1, vb[i], i);

        repeat (3) @(posedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending entries required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1);
    end

endmodule
